instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Parametrised instruction-fetch stage with a PC register, a redirect path for branches and jumps, and stall and squash handling. It drives an external synchronous instruction ROM that has one cycle of read latency. It presents instruction, PC+step and a valid flag to the IF/ID register. A hold buffer preserves an instruction that returns from the ROM during a stall, so nothing is lost or duplicated.

Parameters:
WIDTH_B, 32, data and PC width in bits
ADDR_B, 10, ROM address width; imem_addr_o = pc_q[ADDR_B-1:0]
PC_STEP, 1, PC increment per sequential fetch (1 = word-addressed, 4 = byte-addressed)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
pc_write_i  in  1  1 = advance; 0 = stall (from hazard detection unit)
redirect_i  in  1  branch taken / jump: squash wrong-path fetches and load redirect_pc_i
redirect_pc_i  in  WIDTH_B  redirect target PC
imem_en_o  out  1  ROM read enable
imem_addr_o  out  ADDR_B  ROM address
imem_rdata_i  in  WIDTH_B  ROM data, valid the cycle after imem_en_o=1 is sampled
instr_o  out  WIDTH_B  fetched instruction to IF/ID
pc_plus_o  out  WIDTH_B  PC of instr_o + PC_STEP
instr_valid_o  out  1  instr_o / pc_plus_o are valid, non-squashed
fetch_count_o  out  WIDTH_B  count of delivered instructions, saturating

Behaviour:
- Registers and reset values:
  - pc_q = RESET_PC
  - f2_valid_q = 0; f2_pcp_q = 0
  - hold_q = 0; hold_pcp_q = 0
  - state = RUN
  - fetch_count_o = 0
- Reset acts immediately and asynchronously, including mid-operation. While rst_n=0, imem_en_o=0 and instr_valid_o=0.
- imem_addr_o = pc_q[ADDR_B-1:0] at all times. Upper PC bits are ignored, so the ROM wraps modulo 2^ADDR_B.
- pc_q arithmetic is modulo 2^WIDTH_B.
- imem_en_o = rst_n & (redirect_i | pc_write_i).
- States: RUN, HOLD.
- RUN, redirect_i=1 (highest priority):
  - instr_valid_o=0 this cycle.
  - pc_q <= redirect_pc_i; f2_valid_q <= 0; stay RUN.
  - The target is fetched next cycle; first target instruction is valid 2 cycles after redirect.
- RUN, pc_write_i=1:
  - Outputs: instr_o = imem_rdata_i, pc_plus_o = f2_pcp_q, instr_valid_o = f2_valid_q.
  - pc_q <= pc_q + PC_STEP; f2_valid_q <= 1; f2_pcp_q <= pc_q + PC_STEP.
- RUN, pc_write_i=0:
  - imem_en_o=0; pc_q holds.
  - Outputs are the same as in RUN with pc_write_i=1.
  - If f2_valid_q=1: hold_q <= imem_rdata_i; hold_pcp_q <= f2_pcp_q; f2_valid_q <= 0; go HOLD.
  - Otherwise stay RUN.
- HOLD:
  - Outputs: instr_o = hold_q, pc_plus_o = hold_pcp_q, instr_valid_o = 1 (0 if redirect_i=1).
  - pc_write_i=0: everything holds.
  - pc_write_i=1: hold is consumed this cycle; fetch of pc_q is issued; pc_q <= pc_q + PC_STEP; f2_valid_q <= 1; f2_pcp_q <= pc_q + PC_STEP; go RUN.
  - redirect_i=1: hold is discarded; pc_q <= redirect_pc_i; f2_valid_q <= 0; go RUN.
- Simultaneous redirect_i and pc_write_i=0: redirect wins and the redirect is never lost.
- Latency: sequential throughput is 1 instruction/cycle. The first valid instruction appears 1 cycle after reset release (addr RESET_PC).
- fetch_count_o increments on every cycle with instr_valid_o=1 && pc_write_i=1. It saturates at 2^WIDTH_B-1.
- A HOLD instruction is delivered exactly once: it is counted only on its release cycle.

Test Plan:
1. Reset release, pc_write_i=1, ROM[n]=0x100+n:
   - Cycles 1..4 show instr_o=0x100..0x103 and pc_plus_o=1..4, instr_valid_o=1.
   - fetch_count_o=4 after cycle 4.
2. Stall: while instr_o=0x102 is valid, drive pc_write_i=0 for 3 cycles, then 1:
   - 0x102 is held with instr_valid_o=1 throughout.
   - Next valid instruction is 0x103; no duplicate or skip; fetch_count_o increments once for 0x102.
3. Redirect: redirect_i=1, redirect_pc_i=0x20 while at PC 5:
   - instr_valid_o=0 that cycle and the next.
   - Then instr_o=ROM[0x20] with pc_plus_o=0x21.
4. Redirect during HOLD, and redirect with pc_write_i=0 in the same cycle:
   - Hold is dropped; target fetch proceeds; no stale instruction becomes valid.
5. Wrap: RESET_PC=0x3FE, ADDR_B=10, PC_STEP=1:
   - imem_addr_o sequence is 0x3FE, 0x3FF, 0x000.
   - pc_plus_o is 0x3FF, 0x400, 0x401.
   - PC_STEP=4 build: pc_plus_o advances by 4.
6. Async reset mid-stream and in HOLD:
   - Assert rst_n=0 between clock edges: outputs clear immediately and imem_en_o=0.
   - Release: fetch restarts at RESET_PC; fetch_count_o=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-fetch stage. It holds the PC, drives a synchronous instruction
// ROM that has one cycle of read latency, and hands instruction / PC+step /
// valid to the IF/ID register. A one-entry hold buffer catches an instruction
// that returns from the ROM while the pipeline is stalled. The stalled
// instruction is therefore delivered exactly once.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   pc_write_i     1 = advance, 0 = stall
//   redirect_i     branch taken / jump; squashes wrong-path fetches
//   redirect_pc_i  redirect target PC
//   imem_en_o      ROM read enable
//   imem_addr_o    ROM address (low ADDR_B bits of the PC)
//   imem_rdata_i   ROM data, valid the cycle after an enabled read
//   instr_o        fetched instruction
//   pc_plus_o      PC of instr_o plus PC_STEP
//   instr_valid_o  instr_o / pc_plus_o are valid and not squashed
//   fetch_count_o  saturating count of delivered instructions
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned WIDTH_B  = 32,
  parameter int unsigned ADDR_B   = 10,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write_i,
  input  logic               redirect_i,
  input  logic [WIDTH_B-1:0] redirect_pc_i,
  output logic               imem_en_o,
  output logic [ADDR_B-1:0]  imem_addr_o,
  input  logic [WIDTH_B-1:0] imem_rdata_i,
  output logic [WIDTH_B-1:0] instr_o,
  output logic [WIDTH_B-1:0] pc_plus_o,
  output logic               instr_valid_o,
  output logic [WIDTH_B-1:0] fetch_count_o
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [WIDTH_B-1:0] STEP_V  = WIDTH_B'(PC_STEP);
  localparam logic [WIDTH_B-1:0] RESET_V = WIDTH_B'(RESET_PC);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH_B-1:0] pc_q;
  logic [WIDTH_B-1:0] pc_next_seq;
  logic               f2_valid_q;
  logic [WIDTH_B-1:0] f2_pcp_q;
  logic [WIDTH_B-1:0] hold_q;
  logic [WIDTH_B-1:0] hold_pcp_q;
  logic               capture_hold;

  // The PC wraps naturally at WIDTH_B bits. The ROM sees only the low ADDR_B
  // bits, so it wraps at 2^ADDR_B.
  assign pc_next_seq = pc_q + STEP_V;
  assign imem_addr_o = pc_q[ADDR_B-1:0];

  // State register. HOLD means the hold buffer owns the instruction currently
  // presented downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A redirect always returns to RUN. A stall only enters
  // HOLD when an instruction is actually coming back from the ROM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (!redirect_i && !pc_write_i && f2_valid_q) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_i || pc_write_i) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic. In RUN the ROM data goes straight through. In HOLD the
  // buffered copy is presented instead. A redirect kills the valid flag in
  // either state.
  always_comb begin
    instr_o       = imem_rdata_i;
    pc_plus_o     = f2_pcp_q;
    instr_valid_o = 1'b0;
    capture_hold  = 1'b0;
    imem_en_o     = rst_n & (redirect_i | pc_write_i);
    unique case (state_q)
      RUN: begin
        instr_valid_o = rst_n & f2_valid_q & ~redirect_i;
        capture_hold  = ~redirect_i & ~pc_write_i & f2_valid_q;
      end
      HOLD: begin
        instr_o       = hold_q;
        pc_plus_o     = hold_pcp_q;
        instr_valid_o = rst_n & ~redirect_i;
      end
      default: begin
        instr_valid_o = 1'b0;
      end
    endcase
  end

  // PC and fetch-pipeline registers. The priority order is redirect, then
  // advance, then stall. When a stall begins with a fetch in flight, the
  // returning data is parked in the hold buffer, and the in-flight flag is
  // cleared so that the data is not presented twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_V;
      f2_valid_q <= 1'b0;
      f2_pcp_q   <= '0;
      hold_q     <= '0;
      hold_pcp_q <= '0;
    end else if (redirect_i) begin
      pc_q       <= redirect_pc_i;
      f2_valid_q <= 1'b0;
    end else if (pc_write_i) begin
      pc_q       <= pc_next_seq;
      f2_valid_q <= 1'b1;
      f2_pcp_q   <= pc_next_seq;
    end else if (capture_hold) begin
      hold_q     <= imem_rdata_i;
      hold_pcp_q <= f2_pcp_q;
      f2_valid_q <= 1'b0;
    end
  end

  // Delivered-instruction counter. An instruction counts only in the cycle
  // the consumer accepts it. For a held instruction that is its release
  // cycle. The counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_o <= '0;
    end else if (instr_valid_o && pc_write_i && (fetch_count_o != '1)) begin
      fetch_count_o <= fetch_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. The main instance has default
// parameters. Two more instances always advance: one starts at 0x3FE to
// exercise address wrap, and one uses a PC step of 4. Each instance has a
// behavioural ROM that returns 0x100 + address one cycle after an enabled
// read. Inputs change at the falling edge and outputs are sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc_plus;
  logic        valid;
  logic [31:0] count;

  logic        aux_pw;
  logic        aux_rd;
  logic [31:0] aux_rpc;

  logic        w_en;
  logic [9:0]  w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc_plus;
  logic        w_valid;
  logic [31:0] w_count;

  logic        s_en;
  logic [9:0]  s_addr;
  logic [31:0] s_rdata;
  logic [31:0] s_instr;
  logic [31:0] s_pc_plus;
  logic        s_valid;
  logic [31:0] s_count;

  int n_checks;
  int n_fail;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_write_i(pc_write), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_en_o(imem_en), .imem_addr_o(imem_addr),
    .imem_rdata_i(rdata), .instr_o(instr), .pc_plus_o(pc_plus),
    .instr_valid_o(valid), .fetch_count_o(count)
  );

  instr_fetch_unit #(.RESET_PC(32'h3FE)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc_write_i(aux_pw), .redirect_i(aux_rd),
    .redirect_pc_i(aux_rpc), .imem_en_o(w_en), .imem_addr_o(w_addr),
    .imem_rdata_i(w_rdata), .instr_o(w_instr), .pc_plus_o(w_pc_plus),
    .instr_valid_o(w_valid), .fetch_count_o(w_count)
  );

  instr_fetch_unit #(.PC_STEP(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .pc_write_i(aux_pw), .redirect_i(aux_rd),
    .redirect_pc_i(aux_rpc), .imem_en_o(s_en), .imem_addr_o(s_addr),
    .imem_rdata_i(s_rdata), .instr_o(s_instr), .pc_plus_o(s_pc_plus),
    .instr_valid_o(s_valid), .fetch_count_o(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs with one cycle of latency: ROM[n] = 0x100 + n
  always @(posedge clk) begin
    if (imem_en) rdata <= 32'h100 + 32'(imem_addr);
    if (w_en)    w_rdata <= 32'h100 + 32'(w_addr);
    if (s_en)    s_rdata <= 32'h100 + 32'(s_addr);
  end

  // Watchdog in case the clocked sequence never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Pulse reset low between edges. Cycle 0 (fetch of RESET_PC) follows.
  task automatic apply_reset();
    @(negedge clk);
    pc_write = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // Drive inputs for the next cycle, then let the combinational outputs settle
  task automatic next_cycle(input logic pw, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    pc_write = pw;
    redirect = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pc_write = 1'b1;
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_en: got %b want 0", imem_en); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (imem_addr !== 10'h000) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 000", imem_addr); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_en !== 1'b1) begin n_fail++; $display("[TB] FAIL release_en: got %b want 1", imem_en); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_valid: got %b want 0", valid); end
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      next_cycle(1'b1, 1'b0, 32'h0);
      n_checks++;
      if (instr !== 32'h100 + 32'(i) || pc_plus !== 32'(i + 1) || valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL seq_%0d: got instr=%h pcp=%h v=%b want instr=%h pcp=%h v=1",
                 i, instr, pc_plus, valid, 32'h100 + 32'(i), 32'(i + 1));
      end
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++; if (count !== 32'd4) begin n_fail++; $display("[TB] FAIL seq_count: got %0d want 4", count); end
  endtask

  task automatic test_stall();
    apply_reset();
    next_cycle(1'b1, 1'b0, 32'h0);
    next_cycle(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (instr !== 32'h102 || pc_plus !== 32'd3 || valid !== 1'b1 || count !== 32'd2) begin
        n_fail++;
        $display("[TB] FAIL stall_%0d: got instr=%h pcp=%h v=%b cnt=%0d want 102/3/1/2",
                 i, instr, pc_plus, valid, count);
      end
    end
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_en: got %b want 0", imem_en); end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (instr !== 32'h102 || valid !== 1'b1 || imem_addr !== 10'h003) begin
      n_fail++;
      $display("[TB] FAIL stall_release: got instr=%h v=%b addr=%h want 102/1/003", instr, valid, imem_addr);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (instr !== 32'h103 || pc_plus !== 32'd4 || valid !== 1'b1 || count !== 32'd3) begin
      n_fail++;
      $display("[TB] FAIL stall_after: got instr=%h pcp=%h v=%b cnt=%0d want 103/4/1/3",
               instr, pc_plus, valid, count);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int i = 0; i < 4; i++) next_cycle(1'b1, 1'b0, 32'h0);
    next_cycle(1'b1, 1'b1, 32'h20);
    n_checks++;
    if (imem_addr !== 10'h005 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL redir_cycle: got addr=%h v=%b want 005/0", imem_addr, valid);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (imem_addr !== 10'h020 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL redir_bubble: got addr=%h v=%b want 020/0", imem_addr, valid);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (instr !== 32'h120 || pc_plus !== 32'h21 || valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL redir_target: got instr=%h pcp=%h v=%b want 120/21/1", instr, pc_plus, valid);
    end
  endtask

  task automatic test_redirect_hold();
    apply_reset();
    next_cycle(1'b1, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (instr !== 32'h101 || valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL hold_pre: got instr=%h v=%b want 101/1", instr, valid);
    end
    next_cycle(1'b0, 1'b1, 32'h40);
    n_checks++;
    if (valid !== 1'b0 || imem_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL hold_redir: got v=%b en=%b want 0/1", valid, imem_en);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b0 || imem_addr !== 10'h040) begin
      n_fail++;
      $display("[TB] FAIL hold_bubble: got v=%b addr=%h want 0/040", valid, imem_addr);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (instr !== 32'h140 || pc_plus !== 32'h41 || valid !== 1'b1 || count !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL hold_target: got instr=%h pcp=%h v=%b cnt=%0d want 140/41/1/1",
               instr, pc_plus, valid, count);
    end
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    next_cycle(1'b1, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b1, 32'h60);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rs_cycle: got v=%b want 0", valid); end
    next_cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 10'h060) begin
      n_fail++;
      $display("[TB] FAIL rs_stall: got v=%b en=%b addr=%h want 0/0/060", valid, imem_en, imem_addr);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (valid !== 1'b0 || imem_addr !== 10'h060) begin
      n_fail++;
      $display("[TB] FAIL rs_fetch: got v=%b addr=%h want 0/060", valid, imem_addr);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (instr !== 32'h160 || pc_plus !== 32'h61 || valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rs_target: got instr=%h pcp=%h v=%b want 160/61/1", instr, pc_plus, valid);
    end
  endtask

  task automatic test_wrap_step();
    apply_reset();
    n_checks++; if (w_addr !== 10'h3FE) begin n_fail++; $display("[TB] FAIL wrap_addr0: got %h want 3FE", w_addr); end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (w_addr !== 10'h3FF || w_pc_plus !== 32'h3FF || w_instr !== 32'h4FE || w_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrap_1: got addr=%h pcp=%h instr=%h v=%b want 3FF/3FF/4FE/1",
               w_addr, w_pc_plus, w_instr, w_valid);
    end
    n_checks++;
    if (s_pc_plus !== 32'd4 || s_instr !== 32'h100) begin
      n_fail++;
      $display("[TB] FAIL step4_1: got pcp=%h instr=%h want 4/100", s_pc_plus, s_instr);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (w_addr !== 10'h000 || w_pc_plus !== 32'h400 || w_instr !== 32'h4FF) begin
      n_fail++;
      $display("[TB] FAIL wrap_2: got addr=%h pcp=%h instr=%h want 000/400/4FF", w_addr, w_pc_plus, w_instr);
    end
    n_checks++;
    if (s_pc_plus !== 32'd8 || s_instr !== 32'h104) begin
      n_fail++;
      $display("[TB] FAIL step4_2: got pcp=%h instr=%h want 8/104", s_pc_plus, s_instr);
    end
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (w_pc_plus !== 32'h401 || w_instr !== 32'h100) begin
      n_fail++;
      $display("[TB] FAIL wrap_3: got pcp=%h instr=%h want 401/100", w_pc_plus, w_instr);
    end
    n_checks++;
    if (s_pc_plus !== 32'd12 || s_instr !== 32'h108) begin
      n_fail++;
      $display("[TB] FAIL step4_3: got pcp=%h instr=%h want C/108", s_pc_plus, s_instr);
    end
  endtask

  task automatic test_async_reset();
    // Mid-stream: two instructions delivered, then reset between edges
    apply_reset();
    next_cycle(1'b1, 1'b0, 32'h0);
    next_cycle(1'b1, 1'b0, 32'h0);
    next_cycle(1'b1, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_en !== 1'b0 || valid !== 1'b0 || count !== 32'd0 || imem_addr !== 10'h000) begin
      n_fail++;
      $display("[TB] FAIL arst_stream: got en=%b v=%b cnt=%0d addr=%h want 0/0/0/000",
               imem_en, valid, count, imem_addr);
    end
    rst_n = 1'b1;
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (instr !== 32'h100 || pc_plus !== 32'd1 || valid !== 1'b1 || count !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL arst_restart: got instr=%h pcp=%h v=%b cnt=%0d want 100/1/1/0",
               instr, pc_plus, valid, count);
    end
    // In HOLD: reset while the held instruction is presented
    apply_reset();
    next_cycle(1'b1, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b0, 32'h0);
    #2;
    pc_write = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_en !== 1'b0 || valid !== 1'b0 || count !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL arst_hold: got en=%b v=%b cnt=%0d want 0/0/0", imem_en, valid, count);
    end
    rst_n = 1'b1;
    next_cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if (instr !== 32'h100 || pc_plus !== 32'd1 || valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL arst_hold_restart: got instr=%h pcp=%h v=%b want 100/1/1", instr, pc_plus, valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    pc_write = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    aux_pw = 1'b1;
    aux_rd = 1'b0;
    aux_rpc = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_hold();
    test_redirect_stall();
    test_wrap_step();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
